// File: rtl/led_strand_driver.sv
// WS2812B-style one-wire strand driver: fetches GRB colours per LED from led_color_buffer,
// serialises NUM_LEDS x 24 bits MSB first, then holds the line low for the latch period.
module led_strand_driver #(
    parameter int NUM_LEDS          = 50,
    parameter int LED_ADDRESS_WIDTH = $clog2(NUM_LEDS),
    parameter int T0H_CYCLES        = 35,
    parameter int T1H_CYCLES        = 70,
    parameter int PERIOD_CYCLES     = 125,
    parameter int RESET_CYCLES      = 28000
) (
    input  logic                         clk_led,
    input  logic                         rst_n,
    input  logic                         enable,
    output logic [LED_ADDRESS_WIDTH-1:0] next_led_request_address,
    input  logic [7:0]                   green_in,
    input  logic [7:0]                   red_in,
    input  logic [7:0]                   blue_in,
    input  logic                         color_valid,
    output logic                         strand_out,
    output logic                         busy,
    output logic                         frame_done,
    output logic                         underrun
);

    localparam int MAX_CYCLES = (PERIOD_CYCLES > RESET_CYCLES) ? PERIOD_CYCLES : RESET_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(PERIOD_CYCLES - 1);
    localparam logic [CNT_W-1:0] RESET_LAST  = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] T0H_C       = CNT_W'(T0H_CYCLES);
    localparam logic [CNT_W-1:0] T1H_C       = CNT_W'(T1H_CYCLES);
    localparam logic [LED_ADDRESS_WIDTH-1:0] LAST_LED = LED_ADDRESS_WIDTH'(NUM_LEDS - 1);

    // STALL is the underrun wait inside a frame: line held low until the next LED is ready
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_SHIFT = 3'd2;
    localparam logic [2:0] S_STALL = 3'd3;
    localparam logic [2:0] S_LATCH = 3'd4;

    logic [2:0]                   r_state, w_state_d;
    logic [CNT_W-1:0]             r_cnt, w_cnt_d;
    logic [4:0]                   r_bit_idx, w_bit_d;
    logic [LED_ADDRESS_WIDTH-1:0] r_led_idx, w_led_d;
    logic [LED_ADDRESS_WIDTH-1:0] r_addr, w_addr_d;
    logic [23:0]                  r_shift, w_shift_d;
    logic [23:0]                  r_pending;
    logic                         r_pending_ok, w_pending_ok_d;
    logic [1:0]                   r_hold;
    logic                         r_underrun, w_underrun_d;

    logic [23:0] w_color;
    logic        w_ready, w_bit_end, w_led_end, w_latch_end, w_prefetch, w_restart;

    assign w_color     = {green_in, red_in, blue_in};
    // Buffer read latency is 2, so a valid flag is trusted only once the address has been stable
    assign w_ready     = (r_hold == 2'd2) && color_valid;
    assign w_bit_end   = (r_cnt == PERIOD_LAST);
    assign w_led_end   = w_bit_end && (r_bit_idx == 5'd23);
    assign w_latch_end = (r_state == S_LATCH) && (r_cnt == RESET_LAST);
    assign w_prefetch  = ((r_state == S_SHIFT) || (r_state == S_STALL)) &&
                         (r_led_idx != LAST_LED) && !r_pending_ok && w_ready;

    always_comb begin
        w_state_d      = r_state;
        w_cnt_d        = r_cnt;
        w_bit_d        = r_bit_idx;
        w_led_d        = r_led_idx;
        w_shift_d      = r_shift;
        w_pending_ok_d = r_pending_ok | w_prefetch;
        w_underrun_d   = r_underrun;
        case (r_state)
            S_IDLE: begin
                if (enable) w_state_d = S_FETCH;
            end
            S_FETCH: begin
                if (w_ready) begin
                    w_shift_d = w_color;
                    w_led_d   = '0;
                    w_bit_d   = '0;
                    w_cnt_d   = '0;
                    w_state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (w_led_end) begin
                    w_cnt_d = '0;
                    if (r_led_idx == LAST_LED) begin
                        w_state_d = S_LATCH;
                    end else if (r_pending_ok) begin
                        w_shift_d      = r_pending;
                        w_led_d        = r_led_idx + LED_ADDRESS_WIDTH'(1);
                        w_bit_d        = '0;
                        w_pending_ok_d = 1'b0;
                    end else begin
                        w_underrun_d = 1'b1;
                        w_state_d    = S_STALL;
                    end
                end else if (w_bit_end) begin
                    w_cnt_d   = '0;
                    w_bit_d   = r_bit_idx + 5'd1;
                    w_shift_d = {r_shift[22:0], 1'b0};
                end else begin
                    w_cnt_d = r_cnt + CNT_W'(1);
                end
            end
            S_STALL: begin
                if (r_pending_ok) begin
                    w_shift_d      = r_pending;
                    w_led_d        = r_led_idx + LED_ADDRESS_WIDTH'(1);
                    w_bit_d        = '0;
                    w_cnt_d        = '0;
                    w_pending_ok_d = 1'b0;
                    w_state_d      = S_SHIFT;
                end
            end
            S_LATCH: begin
                if (w_latch_end) begin
                    w_cnt_d   = '0;
                    w_state_d = enable ? S_FETCH : S_IDLE;
                end else begin
                    w_cnt_d = r_cnt + CNT_W'(1);
                end
            end
            default: w_state_d = S_IDLE;
        endcase

        if ((w_state_d == S_SHIFT) || (w_state_d == S_STALL)) begin
            w_addr_d = (w_led_d == LAST_LED) ? LAST_LED : w_led_d + LED_ADDRESS_WIDTH'(1);
        end else begin
            w_addr_d = '0;
        end
    end

    assign w_restart = (w_addr_d != r_addr) || ((w_state_d == S_FETCH) && (r_state != S_FETCH));

    always_ff @(posedge clk_led or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_bit_idx    <= '0;
            r_led_idx    <= '0;
            r_addr       <= '0;
            r_shift      <= '0;
            r_pending    <= '0;
            r_pending_ok <= 1'b0;
            r_hold       <= '0;
            r_underrun   <= 1'b0;
        end else begin
            r_state      <= w_state_d;
            r_cnt        <= w_cnt_d;
            r_bit_idx    <= w_bit_d;
            r_led_idx    <= w_led_d;
            r_addr       <= w_addr_d;
            r_shift      <= w_shift_d;
            r_pending_ok <= w_pending_ok_d;
            r_underrun   <= w_underrun_d;
            if (w_prefetch) r_pending <= w_color;
            if (w_restart) begin
                r_hold <= '0;
            end else if (r_hold != 2'd2) begin
                r_hold <= r_hold + 2'd1;
            end
        end
    end

    assign strand_out = (r_state == S_SHIFT) && (r_cnt < (r_shift[23] ? T1H_C : T0H_C));
    assign busy       = (r_state != S_IDLE);
    assign frame_done = w_latch_end;
    assign underrun   = r_underrun;
    assign next_led_request_address = r_addr;

endmodule

// File: tb/tb_led_strand_driver.sv
// Bench for led_strand_driver: buffer model with 2-cycle latency, strand pulse decoder, and
// frame-level expectations computed from the colours and the timing parameters.
module tb_led_strand_driver;

    localparam int N   = 3;
    localparam int T0H = 2;
    localparam int T1H = 4;
    localparam int PER = 6;
    localparam int RST = 20;
    localparam int AW  = $clog2(N);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic [AW-1:0] addr;
    logic [7:0]    g = 8'h0, r = 8'h0, b = 8'h0;
    logic          cv = 1'b0;
    logic          strand, busy, fd, urun;

    always #5 clk = ~clk;

    led_strand_driver #(
        .NUM_LEDS(N), .LED_ADDRESS_WIDTH(AW), .T0H_CYCLES(T0H), .T1H_CYCLES(T1H),
        .PERIOD_CYCLES(PER), .RESET_CYCLES(RST)
    ) dut (
        .clk_led(clk), .rst_n(rst_n), .enable(enable), .next_led_request_address(addr),
        .green_in(g), .red_in(r), .blue_in(b), .color_valid(cv),
        .strand_out(strand), .busy(busy), .frame_done(fd), .underrun(urun)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Buffer model: data for the address seen two cycles ago, valid when it matches the current one
    logic [23:0]   mem [4];
    logic [AW-1:0] a0 = '0, a1 = '0, a2 = '0;
    bit            withhold2 = 1'b0;
    bit            stale_mode = 1'b0;
    bit            prev_busy = 1'b0;
    int            stale_left = 0;

    always @(negedge clk) begin
        a2 = a1;
        a1 = a0;
        a0 = addr;
        {g, r, b} = mem[a2];
        cv = (a2 == a0) && !(withhold2 && (a2 == AW'(2)));
        if (stale_mode && busy && !prev_busy) stale_left = 2;
        if (stale_left > 0) begin
            {g, r, b} = ~mem[0];
            cv = 1'b1;
            stale_left--;
        end
        prev_busy = busy;
    end

    // Strand decoder: high time of each pulse gives the bit value
    int   cyc = 0;
    logic prev_s = 1'b0;
    int   rise_cyc = 0;
    int   last_rise = 0;
    int   bad_pulses = 0;
    bit   bits_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (strand && !prev_s) begin
            rise_cyc  = cyc;
            last_rise = cyc;
        end
        if (!strand && prev_s && rst_n) begin
            if (cyc - rise_cyc == T1H) bits_q.push_back(1'b1);
            else if (cyc - rise_cyc == T0H) bits_q.push_back(1'b0);
            else bad_pulses++;
        end
        prev_s = strand;
    end

    function automatic logic [71:0] decoded(input int first);
        logic [71:0] v = '0;
        for (int i = 0; i < 72; i++) v = {v[70:0], bits_q[first + i]};
        return v;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_frame_done(input string name, output int fdc);
        int t = 0;
        fdc = -1;
        while (t < 3000 && fdc < 0) begin
            @(negedge clk);
            if (fd) fdc = cyc;
            t++;
        end
        if (fdc < 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: frame_done timeout after %0d cycles, required a pulse", name, t);
        end
    endtask

    typedef struct {
        logic [23:0] c0, c1, c2;
        bit          stale;
        int          stall;
        int          drop_bits;
        bit          exp_underrun;
    } vec_t;

    task automatic run_vec(input int idx, input vec_t v);
        int  fdc, t, rise_before;
        bit  low_ok;
        string nm;
        nm = $sformatf("vec%0d", idx);
        do_reset();
        mem[0] = v.c0; mem[1] = v.c1; mem[2] = v.c2; mem[3] = 24'h0;
        stale_mode = v.stale;
        withhold2  = (v.stall > 0);
        bits_q.delete();
        bad_pulses = 0;
        enable = 1'b1;
        t = 0;
        while (!busy && t < 10) begin @(negedge clk); t++; end
        check({nm, "_busy_rise"}, 128'(busy), 128'(1));
        if (v.drop_bits > 0) begin
            t = 0;
            while (bits_q.size() < v.drop_bits && t < 2000) begin @(negedge clk); t++; end
        end
        enable = 1'b0;
        if (v.stall > 0) begin
            t = 0;
            while (!urun && t < 2000) begin @(negedge clk); t++; end
            check({nm, "_underrun_set"}, 128'(urun), 128'(1));
            low_ok = 1'b1;
            for (int i = 0; i < v.stall; i++) begin
                if (strand !== 1'b0) low_ok = 1'b0;
                @(negedge clk);
            end
            check({nm, "_stall_low"}, 128'(low_ok), 128'(1));
            withhold2 = 1'b0;
        end
        wait_frame_done(nm, fdc);
        check({nm, "_bit_count"}, 128'(bits_q.size()), 128'(72));
        if (bits_q.size() >= 72) check({nm, "_bits"}, 128'(decoded(0)), 128'({v.c0, v.c1, v.c2}));
        check({nm, "_pulse_widths"}, 128'(bad_pulses), 128'(0));
        check({nm, "_latch_len"}, 128'(fdc - last_rise), 128'(PER - 1 + RST));
        check({nm, "_underrun"}, 128'(urun), 128'(v.exp_underrun));
        @(negedge clk);
        check({nm, "_idle"}, 128'({busy, addr, fd}), 128'(0));
        rise_before = last_rise;
        repeat (30) @(negedge clk);
        check({nm, "_stays_idle"}, 128'({busy, strand, 32'(last_rise - rise_before)}), 128'(0));
        stale_mode = 1'b0;
    endtask

    vec_t vecs[8];

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not complete, required completion");
        $fatal(1);
    end

    initial begin
        int fdc[3];
        int t;
        bit hold_ok;

        vecs[0] = '{24'hFF0000, 24'h00FF00, 24'h0000AA, 1'b0, 0, 0, 1'b0};
        vecs[1] = '{24'h123456, 24'hABCDEF, 24'h0F0F0F, 1'b1, 0, 0, 1'b0};
        vecs[2] = '{24'h00FF00, 24'h800001, 24'hC3A5E7, 1'b0, 15, 0, 1'b1};
        vecs[3] = '{24'hFF0000, 24'h00FF00, 24'h0000AA, 1'b0, 0, 30, 1'b0};
        for (int i = 4; i < 8; i++) begin
            vecs[i].c0 = 24'($urandom);
            vecs[i].c1 = 24'($urandom);
            vecs[i].c2 = 24'($urandom);
            vecs[i].stale = 1'($urandom);
            vecs[i].stall = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 12)) : 0;
            vecs[i].drop_bits = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 40)) : 0;
            vecs[i].exp_underrun = (vecs[i].stall > 0);
        end

        repeat (3) @(negedge clk);
        check("reset_state", 128'({strand, busy, fd, urun, addr}), 128'(0));
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

        // Continuous frames: three back-to-back frames, spacing fixed by FETCH + bits + latch
        do_reset();
        mem[0] = 24'hA5F00F; mem[1] = 24'h3C0081; mem[2] = 24'h7E11E7;
        bits_q.delete();
        bad_pulses = 0;
        enable = 1'b1;
        for (int f = 0; f < 3; f++) wait_frame_done($sformatf("cont%0d", f), fdc[f]);
        enable = 1'b0;
        check("cont_gap01", 128'(fdc[1] - fdc[0]), 128'(3 + N * 24 * PER + RST));
        check("cont_gap12", 128'(fdc[2] - fdc[1]), 128'(3 + N * 24 * PER + RST));
        check("cont_bit_count", 128'(bits_q.size()), 128'(3 * 72));
        if (bits_q.size() >= 216) begin
            for (int f = 0; f < 3; f++)
                check($sformatf("cont_bits%0d", f), 128'(decoded(72 * f)),
                      128'({mem[0], mem[1], mem[2]}));
        end
        repeat (2) @(negedge clk);
        check("cont_idle", 128'({busy, addr}), 128'(0));

        // Asynchronous reset while the line is high, after an underrun has been flagged
        do_reset();
        withhold2 = 1'b1;
        enable = 1'b1;
        t = 0;
        while (!urun && t < 2000) begin @(negedge clk); t++; end
        check("rst_pre_underrun", 128'(urun), 128'(1));
        withhold2 = 1'b0;
        enable = 1'b0;
        t = 0;
        while (!strand && t < 100) begin @(negedge clk); t++; end
        check("rst_pre_high", 128'(strand), 128'(1));
        rst_n = 1'b0;
        #1;
        check("rst_immediate", 128'({strand, busy, fd, urun, addr}), 128'(0));
        hold_ok = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if ({strand, busy, fd, urun, addr} !== '0) hold_ok = 1'b0;
        end
        check("rst_held", 128'(hold_ok), 128'(1));
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_release_idle", 128'({strand, busy, urun, addr}), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
